instruction_memory_loadable: RTL

Parametrised, runtime-loadable instruction memory for the single-cycle/pipelined MIPS datapath. It replaces the file-initialised, fixed 32x32 fetch store with a block that has:
- configurable word width and depth;
- a streaming load port, so the testbench or boot logic can write the program after reset;
- a registered fetch with a valid strobe;
- explicit fault reporting: misaligned, out-of-range and not-ready fetches.

It sits between the PC register and the IF/ID stage.

---
 rtl/instruction_memory_loadable.sv | 117 +++++++++++
 1 files changed

// File: rtl/instruction_memory_loadable.sv
// Runtime-loadable instruction memory for the MIPS fetch stage: a streaming
// load port fills the array after reset, and fetches are registered with fault flags.
module instruction_memory_loadable #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [DATA_WIDTH-1:0]    load_data,
  input  logic                     load_done,
  input  logic                     fetch_req,
  input  logic [ADDR_WIDTH-1:0]    address,
  output logic [DATA_WIDTH-1:0]    instruc,
  output logic                     fetch_valid,
  output logic                     fault_misaligned,
  output logic                     fault_range,
  output logic                     fault_notready,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   loaded_count,
  output logic                     load_overflow
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int BYTE_SH = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((DATA_WIDTH / 8) - 1);
  localparam logic [IDX_W:0]        FULL_COUNT = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]      LAST_INDEX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [IDX_W-1:0]        wr_ptr;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   word_index;
  logic                    is_ready;
  logic                    misaligned;
  logic                    in_range;
  logic                    fetch_ok;

  // The write pointer is always the number of words written so far.
  assign wr_ptr     = loaded_count[IDX_W-1:0];
  assign mem_we     = (state == LOADING) && load_valid && !load_start;

  assign word_index = address >> BYTE_SH;
  assign is_ready   = (state == READY);
  assign misaligned = |(address & ALIGN_MASK);
  assign in_range   = word_index < ADDR_WIDTH'(loaded_count);
  assign fetch_ok   = is_ready && !misaligned && in_range;

  assign ready      = is_ready;

  // NOTE: the array has no reset; clearing it would turn it into flops and
  // the contents are allowed to be undefined after reset anyway.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[wr_ptr] <= load_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= EMPTY;
      loaded_count     <= '0;
      load_overflow    <= 1'b0;
      instruc          <= '0;
      fetch_valid      <= 1'b0;
      fault_misaligned <= 1'b0;
      fault_range      <= 1'b0;
      fault_notready   <= 1'b0;
    end else begin
      // Fetch is evaluated on the pre-edge state and count.
      fetch_valid      <= fetch_req;
      fault_notready   <= fetch_req && !is_ready;
      fault_misaligned <= fetch_req && is_ready && misaligned;
      fault_range      <= fetch_req && is_ready && !misaligned && !in_range;
      if (fetch_req) begin
        instruc <= fetch_ok ? mem[word_index[IDX_W-1:0]] : NOP_WORD;
      end

      if (load_start) begin
        state         <= LOADING;
        loaded_count  <= '0;
        load_overflow <= 1'b0;
      end else begin
        unique case (state)
          LOADING: begin
            if (load_valid) begin
              loaded_count <= loaded_count + 1'b1;
            end
            if (load_done || (load_valid && wr_ptr == LAST_INDEX)) begin
              state <= READY;
            end
          end
          READY: begin
            if (load_valid && loaded_count == FULL_COUNT) begin
              load_overflow <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
